// File: rtl/instr_fetch_seq.sv
// Two-byte instruction fetch sequencer: reads PC and PC+1, loads the IR low/high halves, bumps PC per byte.
// Optional per-request timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_seq #(
  parameter logic [3:0]  PC_REG_SEL = 4'b1000,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       flush,
  input  logic [7:0] pc_in,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] ir_data,
  output logic       ir_lh,
  output logic       ir_enable,
  output logic [1:0] ir_select,
  output logic [1:0] pc_fun_sel,
  output logic [3:0] pc_reg_sel,
  output logic       busy,
  output logic       instr_valid,
  output logic       fault
);

  localparam int unsigned BYTE_W = 8;
  localparam logic [1:0]  IR_LOAD = 2'b01;
  localparam logic [1:0]  PC_INC  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_LO  = 3'd1,
    S_LOAD_LO = 3'd2,
    S_REQ_HI  = 3'd3,
    S_LOAD_HI = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                fault_q, fault_d;

  logic                mem_req_q, mem_req_d;
  logic                ir_lh_q, ir_lh_d;
  logic                ir_enable_q, ir_enable_d;
  logic [1:0]          ir_select_q, ir_select_d;
  logic [1:0]          pc_fun_sel_q, pc_fun_sel_d;
  logic [3:0]          pc_reg_sel_q, pc_reg_sel_d;
  logic                busy_q, busy_d;
  logic                instr_valid_q, instr_valid_d;
  logic                load_c;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                timeout_c;

  // Fires on the last permitted un-acked REQ cycle.
  assign timeout_c = (wait_q == CNT_W'(TIMEOUT - 1));
`else
  logic                unused_timeout;

  assign unused_timeout = ^TIMEOUT;
`endif

  // Next-state and datapath updates; flush overrides everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = pc_in;
          state_d = S_REQ_LO;
        end
      end
      S_REQ_LO, S_REQ_HI: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = (state_q == S_REQ_LO) ? S_LOAD_LO : S_LOAD_HI;
`ifdef FETCH_TIMEOUT_EN
        end else if (timeout_c) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
        end else begin
          wait_d  = wait_q + CNT_W'(1);
`endif
        end
      end
      S_LOAD_LO: begin
        addr_d  = addr_q + BYTE_W'(1);
        state_d = S_REQ_HI;
      end
      S_LOAD_HI: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      data_d  = data_q;
      fault_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_d  = '0;
`endif
    end
  end

  // Moore outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    load_c        = (state_d == S_LOAD_LO) || (state_d == S_LOAD_HI);
    mem_req_d     = (state_d == S_REQ_LO) || (state_d == S_REQ_HI);
    ir_enable_d   = load_c;
    ir_select_d   = load_c ? IR_LOAD : 2'b00;
    ir_lh_d       = (state_d == S_LOAD_HI);
    pc_fun_sel_d  = load_c ? PC_INC : 2'b00;
    pc_reg_sel_d  = load_c ? PC_REG_SEL : 4'b0000;
    busy_d        = (state_d != S_IDLE);
    instr_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      fault_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      ir_lh_q       <= 1'b0;
      ir_enable_q   <= 1'b0;
      ir_select_q   <= 2'b00;
      pc_fun_sel_q  <= 2'b00;
      pc_reg_sel_q  <= 4'b0000;
      busy_q        <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      fault_q       <= fault_d;
      mem_req_q     <= mem_req_d;
      ir_lh_q       <= ir_lh_d;
      ir_enable_q   <= ir_enable_d;
      ir_select_q   <= ir_select_d;
      pc_fun_sel_q  <= pc_fun_sel_d;
      pc_reg_sel_q  <= pc_reg_sel_d;
      busy_q        <= busy_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q        <= wait_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;
  assign ir_data     = data_q;
  assign ir_lh       = ir_lh_q;
  assign ir_enable   = ir_enable_q;
  assign ir_select   = ir_select_q;
  assign pc_fun_sel  = pc_fun_sel_q;
  assign pc_reg_sel  = pc_reg_sel_q;
  assign busy        = busy_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Randomized bench for instr_fetch_seq: models the external IR and PC register and checks fetch outcomes.
module tb_instr_fetch_seq;

  localparam logic [3:0] PC_SEL = 4'b1000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] pc_in = 8'h00;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] ir_data;
  logic       ir_lh;
  logic       ir_enable;
  logic [1:0] ir_select;
  logic [1:0] pc_fun_sel;
  logic [3:0] pc_reg_sel;
  logic       busy;
  logic       instr_valid;
  logic       fault;

  int checks = 0;
  int errors = 0;

  // Observed effects on the surrounding IR/ARF, updated only by the monitor.
  int          cyc = 0;
  logic [15:0] ir_model = 16'h0000;
  int          ir_writes = 0;
  int          pc_incs = 0;
  int          valid_cnt = 0;
  int          valid_cyc = 0;
  int          fault_cnt = 0;
  int          fault_cyc = 0;

  instr_fetch_seq #(.PC_REG_SEL(PC_SEL), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .flush(flush), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_data(ir_data), .ir_lh(ir_lh), .ir_enable(ir_enable), .ir_select(ir_select),
    .pc_fun_sel(pc_fun_sel), .pc_reg_sel(pc_reg_sel), .busy(busy),
    .instr_valid(instr_valid), .fault(fault)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (ir_enable && ir_select == 2'b01) begin
      if (ir_lh) ir_model[15:8] = ir_data;
      else       ir_model[7:0]  = ir_data;
      ir_writes = ir_writes + 1;
    end
    if (pc_fun_sel == 2'b11 && pc_reg_sel == PC_SEL) pc_incs = pc_incs + 1;
    if (instr_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (fault) begin
      fault_cnt = fault_cnt + 1;
      fault_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({mem_req, busy, ir_enable, ir_lh, instr_valid, fault} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {mem_req, busy, ir_enable, ir_lh, instr_valid, fault});
    end
    checks++;
    if ({ir_select, pc_fun_sel, pc_reg_sel} !== 8'h00) begin
      errors++;
      $display("FAIL reset_sel: got %h expected 00", {ir_select, pc_fun_sel, pc_reg_sel});
    end
    checks++;
    if ({mem_addr, ir_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0000", {mem_addr, ir_data});
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // One fetch with dlo/dhi extra wait cycles; flush_hi aborts on the high-byte ack.
  task automatic run_fetch(input logic [7:0] pc, input logic [7:0] lo, input logic [7:0] hi,
                           input int dlo, input int dhi, input bit flush_hi);
    int base, w, nreq, irw0, pci0, vc0;
    int req_cycles[2];
    int dl[2];
    logic [7:0] bytes[2];
    logic [7:0] exp_addr;
    logic [15:0] ir0, exp_ir;
    bit addr_ok, done;
    bytes[0] = lo; bytes[1] = hi; dl[0] = dlo; dl[1] = dhi;
    req_cycles[0] = 0; req_cycles[1] = 0;
    ir0 = ir_model; irw0 = ir_writes; pci0 = pc_incs; vc0 = valid_cnt;
    start = 1'b1; pc_in = pc; flush = 1'b0;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
    base = cyc;
    tick();
    start = 1'b0; pc_in = 8'($urandom);
    nreq = 0; w = 0; addr_ok = 1'b1; done = 1'b0;
    for (int k = 1; k <= 80 && !done; k++) begin
      flush = 1'b0;
      if (mem_req) begin
        if (nreq < 2) begin
          exp_addr = (nreq == 0) ? pc : pc + 8'd1;
          if (mem_addr !== exp_addr) addr_ok = 1'b0;
          req_cycles[nreq]++;
          w++;
          mem_ack = (w > dl[nreq]);
          mem_rdata = mem_ack ? bytes[nreq] : 8'($urandom);
          if (flush_hi && nreq == 1 && mem_ack) flush = 1'b1;
          if (mem_ack) begin
            nreq++;
            w = 0;
          end
        end else begin
          addr_ok = 1'b0;
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
      end
      @(negedge clock);
      if (!busy) done = 1'b1;
      tick();
    end
    mem_ack = 1'b0; flush = 1'b0;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fetch_done: busy never fell for pc %h, got busy=%b expected 0", pc, busy);
    end
    checks++;
    if (!addr_ok || req_cycles[0] != dlo + 1 || req_cycles[1] != dhi + 1) begin
      errors++;
      $display("FAIL fetch_req: pc %h addr_ok=%0b req_cycles %0d/%0d expected 1/%0d/%0d",
               pc, addr_ok, req_cycles[0], req_cycles[1], dlo + 1, dhi + 1);
    end
    exp_ir = flush_hi ? {ir0[15:8], lo} : {hi, lo};
    checks++;
    if (ir_model !== exp_ir || ir_writes - irw0 != (flush_hi ? 1 : 2)) begin
      errors++;
      $display("FAIL fetch_ir: got %h (%0d writes) expected %h (%0d writes)",
               ir_model, ir_writes - irw0, exp_ir, flush_hi ? 1 : 2);
    end
    checks++;
    if (pc_incs - pci0 != (flush_hi ? 1 : 2)) begin
      errors++;
      $display("FAIL fetch_pc_inc: got %0d expected %0d", pc_incs - pci0, flush_hi ? 1 : 2);
    end
    checks++;
    if (flush_hi) begin
      if (valid_cnt != vc0) begin
        errors++;
        $display("FAIL fetch_valid: got %0d pulses expected 0", valid_cnt - vc0);
      end
    end else if (valid_cnt - vc0 != 1 || valid_cyc - base != 5 + dlo + dhi) begin
      errors++;
      $display("FAIL fetch_valid: got %0d pulses at cycle %0d expected 1 at cycle %0d",
               valid_cnt - vc0, valid_cyc - base, 5 + dlo + dhi);
    end
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle: got busy=%b mem_req=%b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_basic();
    run_fetch(8'h10, 8'h34, 8'h12, 0, 0, 1'b0);
    checks++;
    if (ir_model !== 16'h1234) begin
      errors++;
      $display("FAIL basic_ir: got %h expected 1234", ir_model);
    end
  endtask

  task automatic test_wait_states();
    run_fetch(8'($urandom), 8'($urandom), 8'($urandom), 3, 3, 1'b0);
  endtask

  task automatic test_wrap();
    run_fetch(8'hFF, 8'h5A, 8'hC3, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_fetch(8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);
  endtask

  task automatic test_flush_hi();
    run_fetch(8'h80, 8'hAA, 8'h77, 0, 0, 1'b0);
    run_fetch(8'h90, 8'h11, 8'h99, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    run_fetch(8'hA0, 8'h22, 8'h33, 1, 0, 1'b0);
  endtask

  task automatic test_start_held();
    int base, irw0, pci0;
    start = 1'b1; pc_in = 8'h22; flush = 1'b0; mem_ack = 1'b0;
    base = cyc;
    for (int k = 1; k <= 7; k++) begin
      tick();
      mem_ack = mem_req;
      mem_rdata = 8'($urandom);
      @(negedge clock);
      if (k == 5) begin
        checks++;
        if (instr_valid !== 1'b1) begin
          errors++;
          $display("FAIL held_valid: got %b expected 1", instr_valid);
        end
      end
      if (k == 6) begin
        checks++;
        if ({busy, mem_req} !== 2'b00) begin
          errors++;
          $display("FAIL held_idle: got busy,req=%b expected 00", {busy, mem_req});
        end
      end
      if (k == 7) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h22) begin
          errors++;
          $display("FAIL held_restart: got req=%b addr=%h expected 1 22", mem_req, mem_addr);
        end
      end
    end
    irw0 = ir_writes; pci0 = pc_incs;
    flush = 1'b1; start = 1'b0;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
    tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || ir_writes != irw0 || pc_incs != pci0) begin
      errors++;
      $display("FAIL flush_ack_lo: got busy=%b req=%b writes=%0d incs=%0d expected 0 0 0 0",
               busy, mem_req, ir_writes - irw0, pc_incs - pci0);
    end
    if (base < 0) errors++;
  endtask

  task automatic test_reset_mid();
    int irw0, pci0;
    irw0 = ir_writes; pci0 = pc_incs;
    start = 1'b1; pc_in = 8'h40; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin
      errors++;
      $display("FAIL rst_mid_pre: got req=%b addr=%h expected 1 40", mem_req, mem_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, ir_enable, instr_valid, fault, ir_select, pc_reg_sel} !== 11'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got %b expected all 0",
               {mem_req, busy, ir_enable, instr_valid, fault, ir_select, pc_reg_sel});
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_addr !== 8'h00 || ir_data !== 8'h00 || busy !== 1'b0 ||
        ir_writes != irw0 || pc_incs != pci0) begin
      errors++;
      $display("FAIL rst_mid_after: got addr=%h data=%h busy=%b writes=%0d incs=%0d expected 00 00 0 0 0",
               mem_addr, ir_data, busy, ir_writes - irw0, pc_incs - pci0);
    end
    tick();
  endtask

  task automatic test_timeout();
    int base, fc0, pci0;
    fc0 = fault_cnt; pci0 = pc_incs;
    start = 1'b1; pc_in = 8'h5C; mem_ack = 1'b0; flush = 1'b0;
    base = cyc;
    tick();
    start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      tick();
    end
    checks++;
    if (fault_cnt - fc0 != 1 || fault_cyc - base != 16) begin
      errors++;
      $display("FAIL timeout_fault: got %0d pulses at cycle %0d expected 1 at cycle 16",
               fault_cnt - fc0, fault_cyc - base);
    end
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pc_incs != pci0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b req=%b incs=%0d expected 0 0 0",
               busy, mem_req, pc_incs - pci0);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      tick();
    end
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || fault_cnt != fc0 || pc_incs != pci0) begin
      errors++;
      $display("FAIL no_timeout_wait: got req=%b busy=%b faults=%0d incs=%0d expected 1 1 0 0",
               mem_req, busy, fault_cnt - fc0, pc_incs - pci0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_lo: got busy=%b req=%b expected 0 0", busy, mem_req);
    end
    tick();
`endif
    if (base < 0) errors++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_wrap();
    test_random();
    test_flush_hi();
    test_start_held();
    test_reset_mid();
    test_timeout();
    test_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction-fetch sequencer that sits directly upstream of the 16-bit instruction register (part2a_IR) and beside the address register file (part2c_ARF).
- On each start it reads two 8-bit bytes from memory at PC and PC+1 over a req/ack handshake.
- It loads the low byte, then the high byte, into the IR using that block's LH/enable/select controls.
- It increments PC in the ARF once per byte and pulses instr_valid when the 16-bit instruction is complete.

Parameters:
- PC_REG_SEL, 4'b1000: one-hot ARF reg_sel pattern that addresses PC.
- TIMEOUT, 15: maximum wait cycles per memory request. Used only with FETCH_TIMEOUT_EN.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a fetch; sampled only in IDLE
- flush  in  1  synchronous abort; returns to IDLE from any state
- pc_in  in  8  current PC (ARF outA with OutASel = PC)
- mem_req  out  1  memory read request
- mem_addr  out  8  memory read address
- mem_ack  in  1  memory data valid / request accepted
- mem_rdata  in  8  memory read data
- ir_data  out  8  byte to IR `in`
- ir_lh  out  1  IR half select: 0 = bits 7:0, 1 = bits 15:8
- ir_enable  out  1  IR enable
- ir_select  out  2  IR function select (01 = load)
- pc_fun_sel  out  2  ARF fun_sel (11 = increment)
- pc_reg_sel  out  4  ARF reg_sel
- busy  out  1  high in every state except IDLE
- instr_valid  out  1  one-cycle pulse when the IR holds the new instruction
- fault  out  1  one-cycle timeout pulse; tied 0 without FETCH_TIMEOUT_EN

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is the only clock. On reset:
  - state = IDLE, addr_q = 0, data_q = 0.
  - All outputs are 0: mem_req, ir_enable, ir_select = 00, pc_reg_sel = 0000, instr_valid, fault, busy.
  - A reset mid-operation drops mem_req immediately and performs no IR or PC write.
- States: IDLE, REQ_LO, LOAD_LO, REQ_HI, LOAD_HI, DONE. Outputs are Moore-decoded from the registered state; mem_addr = addr_q and ir_data = data_q.
- IDLE: when start = 1, addr_q <= pc_in and go to REQ_LO.
- REQ_LO: mem_req = 1. mem_req is held high, with mem_addr stable, until mem_ack. On the mem_ack cycle, data_q <= mem_rdata and go to LOAD_LO.
- LOAD_LO (1 cycle):
  - ir_enable = 1, ir_select = 01, ir_lh = 0.
  - pc_fun_sel = 11, pc_reg_sel = PC_REG_SEL.
  - addr_q <= addr_q + 1, modulo 256 (0xFF wraps to 0x00).
  - Go to REQ_HI.
- REQ_HI: same as REQ_LO; on mem_ack go to LOAD_HI.
- LOAD_HI (1 cycle): same as LOAD_LO but ir_lh = 1 and addr_q is unchanged. Go to DONE.
- DONE (1 cycle): instr_valid = 1, then IDLE. A start sampled in DONE is ignored.
- Outside the LOAD states: ir_enable = 0, ir_select = 00, pc_fun_sel = 00, pc_reg_sel = 0000.
- Minimum latency with ack in the first REQ cycle: start sampled at edge 0 → instr_valid high in cycle 5. Exactly 2 PC increments per fetch.
- mem_ack outside the REQ states is ignored.
- flush has priority over every other event. On the next edge: state = IDLE, mem_req drops. If flush coincides with mem_ack, data is discarded and no LOAD state follows. flush in a LOAD state cancels that state's successor, but the LOAD outputs of the current cycle still take effect.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to REQ_LO/REQ_HI and increments each REQ cycle without mem_ack.
  - If it reaches TIMEOUT before ack: fault = 1 for one cycle, state → IDLE, mem_req drops, no IR/PC write.
  - Counter width is ceil(log2(TIMEOUT+1)).
- Undefined: no counter; REQ states wait indefinitely; fault is constant 0.

Test Plan:
- Basic fetch: pc_in = 0x10, start pulse, ack same cycle as req, rdata 0x34 then 0x12 → mem_addr 0x10 then 0x11; LH = 0 load of 0x34, LH = 1 load of 0x12; IR = 0x1234; two PC increment cycles; instr_valid in cycle 5; busy low after.
- Wait states: ack delayed 3 cycles on each byte → mem_req and mem_addr held stable; instr_valid at cycle 11; no IR/PC activity during the waits.
- Wrap: pc_in = 0xFF → second request address is 0x00.
- Flush with ack in REQ_HI → no LOAD_HI; IR high byte unchanged; exactly one PC increment; next start fetches normally.
- Reset: reset_n low during REQ_LO → mem_req falls asynchronously and all outputs are 0. With start held high in DONE, no second fetch occurs until start is seen in IDLE.
- With FETCH_TIMEOUT_EN and TIMEOUT = 15, never ack → fault pulse exactly 15 cycles after REQ_LO entry, state IDLE, zero PC increments. Without the macro → still waiting after 100 cycles, fault = 0.
